// File: rtl/cmd_tx.sv
// Response framer: queues (addr, data) response words and serializes each one
// into a 9-byte frame (HDR0 HDR1 addr d3 d2 d1 d0 checksum TRAILER) for the TX byte FIFO.
module cmd_tx #(
    parameter int         QDEPTH  = 4,
    parameter logic [7:0] HDR0    = 8'h55,
    parameter logic [7:0] HDR1    = 8'hA5,
    parameter logic [7:0] TRAILER = 8'hF0
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [7:0]  rsp_addr,
    input  logic [31:0] rsp_data,
    input  logic        fifo_full,
    output logic        fifo_wrreq,
    output logic [7:0]  fifo_wrdata,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int AW = $clog2(QDEPTH);
    localparam int PW = AW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [3:0] LAST_IDX = 4'd8;

    logic [39:0]    mem_q [QDEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           rsp_ready_q, rsp_ready_d;
    logic [0:0]     state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [39:0]    frame_q, frame_d;
    logic [7:0]     csum_q, csum_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;

    logic           push;
    logic           pop;
    logic           empty;
    logic           full_next;
    logic           wr_fire;
    logic [39:0]    head;
    logic [7:0]     cur_byte;

    // Queue bookkeeping; ready is registered from the post-edge occupancy.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        push      = rsp_valid && rsp_ready_q;
        pop       = (state_q == ST_IDLE) && !empty;
        wr_ptr_d  = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d  = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        full_next = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                    (wr_ptr_d[AW] != rd_ptr_d[AW]);
        rsp_ready_d = !full_next;
        head      = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {rsp_addr, rsp_data};
        end
    end

    assign wr_fire = (state_q == ST_SEND) && !fifo_full;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_d     = frame_q;
        csum_d      = csum_q;
        frame_cnt_d = frame_cnt_q;
        if (state_q == ST_IDLE) begin
            if (pop) begin
                frame_d = head;
                csum_d  = head[39:32] + head[31:24] + head[23:16] + head[15:8] + head[7:0];
                idx_d   = 4'd0;
                state_d = ST_SEND;
            end
        end else begin
            if (wr_fire) begin
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
        end
    end

    // Byte mux over the frame register; held steady while the FIFO stalls us.
    always_comb begin
        cur_byte = 8'h00;
        if (state_q == ST_SEND) begin
            case (idx_q)
                4'd0:    cur_byte = HDR0;
                4'd1:    cur_byte = HDR1;
                4'd2:    cur_byte = frame_q[39:32];
                4'd3:    cur_byte = frame_q[31:24];
                4'd4:    cur_byte = frame_q[23:16];
                4'd5:    cur_byte = frame_q[15:8];
                4'd6:    cur_byte = frame_q[7:0];
                4'd7:    cur_byte = csum_q;
                4'd8:    cur_byte = TRAILER;
                default: cur_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rsp_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            frame_q     <= 40'd0;
            csum_q      <= 8'h00;
            frame_cnt_q <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rsp_ready_q <= rsp_ready_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            csum_q      <= csum_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign rsp_ready   = rsp_ready_q;
    assign fifo_wrreq  = wr_fire;
    assign fifo_wrdata = cur_byte;
    assign busy        = (state_q == ST_SEND) || !empty;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cmd_tx.sv
// Bench for cmd_tx: vector table, directed multi-cycle sequences and random
// traffic, all checked against a byte-stream model of the frame format.
module tb_cmd_tx;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic        fifo_full;
    logic        fifo_wrreq;
    logic [7:0]  fifo_wrdata;
    logic        busy;
    logic [15:0] frame_cnt;

    always #5 Clk = ~Clk;

    cmd_tx #(
        .QDEPTH  (4),
        .HDR0    (8'h55),
        .HDR1    (8'hA5),
        .TRAILER (8'hF0)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_addr    (rsp_addr),
        .rsp_data    (rsp_data),
        .fifo_full   (fifo_full),
        .fifo_wrreq  (fifo_wrreq),
        .fifo_wrdata (fifo_wrdata),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  csum;
    } vec_t;

    vec_t       vecs [7];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         busy_last = 0;
    int         exp_frames = 0;
    logic       rdy_s;
    logic       busy_s;
    bit         rand_stall = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] cap_b [$];
    int         cap_t [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample/score at negedge, then advance past the posedge.
    task automatic step();
        @(negedge Clk);
        rdy_s  = rsp_ready;
        busy_s = busy;
        if (busy) busy_last = cyc;
        if (fifo_wrreq) begin
            chk("no_write_while_full", {31'd0, fifo_full}, 32'd0);
            cap_b.push_back(fifo_wrdata);
            cap_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h want none (cycle %0d)", fifo_wrdata, cyc);
            end else begin
                chk("fifo_byte", {24'd0, fifo_wrdata}, {24'd0, exp_q.pop_front()});
            end
        end
        @(posedge Clk);
        cyc++;
        #1;
        if (rand_stall) fifo_full = ($urandom_range(0, 3) == 0);
    endtask

    function automatic void add_frame(input logic [7:0] a, input logic [31:0] d);
        int s;
        s = int'(a) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA5);
        exp_q.push_back(a);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(8'(s % 256));
        exp_q.push_back(8'hF0);
    endfunction

    task automatic push_word(input logic [7:0] a, input logic [31:0] d, output int acc);
        rsp_valid = 1'b1;
        rsp_addr  = a;
        rsp_data  = d;
        acc = -1;
        for (int n = 0; n < 300; n++) begin
            step();
            if (rdy_s) begin
                acc = cyc;
                break;
            end
        end
        rsp_valid = 1'b0;
        if (acc < 0) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got no accept want accept of addr %0h", a);
        end else begin
            add_frame(a, d);
            exp_frames++;
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (!busy_s && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=%0d pending=%0d want idle", busy, exp_q.size());
        end
    endtask

    task automatic clear_cap();
        cap_b.delete();
        cap_t.delete();
    endtask

    initial begin
        int acc;
        int acc6 [6];

        vecs[0] = '{8'h03, 32'h12345678, 8'h17};
        vecs[1] = '{8'hFF, 32'hFFFFFFFF, 8'hFB};
        vecs[2] = '{8'h00, 32'h00000000, 8'h00};
        vecs[3] = '{8'h01, 32'h01010101, 8'h05};
        vecs[4] = '{8'h80, 32'h80000000, 8'h00};
        vecs[5] = '{8'h10, 32'h00000001, 8'h11};
        vecs[6] = '{8'hAA, 32'h55555555, 8'hFE};

        // Clock / reset
        Rst_n     = 1'b1;
        rsp_valid = 1'b0;
        rsp_addr  = 8'h00;
        rsp_data  = 32'h0;
        fifo_full = 1'b0;
        #2 Rst_n = 1'b0;
        #1;
        chk("reset_rsp_ready", {31'd0, rsp_ready}, 32'd1);
        chk("reset_wrreq", {31'd0, fifo_wrreq}, 32'd0);
        chk("reset_wrdata", {24'd0, fifo_wrdata}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1 Rst_n = 1'b1;

        // Vector table: one isolated frame per entry
        for (int i = 0; i < 7; i++) begin
            clear_cap();
            push_word(vecs[i].addr, vecs[i].data, acc);
            wait_idle(100);
            chk("frame_len", cap_b.size(), 9);
            if (cap_b.size() == 9) begin
                chk("checksum", {24'd0, cap_b[7]}, {24'd0, vecs[i].csum});
                chk("no_gaps", cap_t[8] - cap_t[0], 8);
                chk("first_byte_latency", cap_t[0], acc + 1);
                chk("busy_drop", busy_last, cap_t[8]);
            end
            chk("frame_cnt", {16'd0, frame_cnt}, exp_frames);
        end

        // Queue full: six consecutive offers, QDEPTH=4
        clear_cap();
        for (int i = 0; i < 6; i++) begin
            push_word(8'h20 + 8'(i), 32'(i + 1), acc);
            acc6[i] = acc;
            if (i == 4) chk("ready_low_when_full", {31'd0, rsp_ready}, 32'd0);
        end
        for (int i = 1; i < 5; i++) chk("consecutive_accept", acc6[i] - acc6[0], i);
        chk("sixth_accept_after_pop", acc6[5] - acc6[0], 12);
        wait_idle(300);
        chk("six_frames_len", cap_b.size(), 54);
        if (cap_b.size() == 54) begin
            for (int f = 1; f < 6; f++) chk("one_gap_between_frames", cap_t[9*f] - cap_t[9*f-1], 2);
        end
        chk("frame_cnt_after_full", {16'd0, frame_cnt}, exp_frames);

        // Stall 5 cycles while data[31:24] is presented
        clear_cap();
        push_word(8'h3C, 32'hDEADBEEF, acc);
        for (int n = 0; n < 50 && cap_b.size() < 3; n++) step();
        chk("stall_reached_idx3", cap_b.size(), 3);
        fifo_full = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("stall_no_wrreq", {31'd0, fifo_wrreq}, 32'd0);
            chk("stall_data_stable", {24'd0, fifo_wrdata}, 32'h0000_00DE);
        end
        fifo_full = 1'b0;
        wait_idle(100);
        chk("stall_frame_len", cap_b.size(), 9);
        if (cap_b.size() == 9) begin
            chk("stall_span", cap_t[8] - cap_t[0], 13);
            chk("stall_gap", cap_t[3] - cap_t[2], 6);
        end

        // Random traffic with random FIFO back-pressure
        rand_stall = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int idle_n;
            idle_n = $urandom_range(0, 3);
            for (int n = 0; n < idle_n; n++) step();
            push_word(8'($urandom_range(0, 255)), $urandom, acc);
        end
        rand_stall = 1'b0;
        fifo_full  = 1'b0;
        wait_idle(2000);
        chk("frame_cnt_random", {16'd0, frame_cnt}, exp_frames);

        // Reset mid-frame with two words queued
        clear_cap();
        push_word(8'h41, 32'hA1A2A3A4, acc);
        push_word(8'h42, 32'hB1B2B3B4, acc);
        push_word(8'h43, 32'hC1C2C3C4, acc);
        for (int n = 0; n < 50 && cap_b.size() < 5; n++) step();
        chk("midreset_bytes_before", cap_b.size(), 5);
        Rst_n = 1'b0;
        #1;
        chk("midreset_rsp_ready", {31'd0, rsp_ready}, 32'd1);
        chk("midreset_wrreq", {31'd0, fifo_wrreq}, 32'd0);
        chk("midreset_wrdata", {24'd0, fifo_wrdata}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        exp_q.delete();
        exp_frames = 0;
        step();
        step();
        Rst_n = 1'b1;
        for (int n = 0; n < 30; n++) step();
        chk("midreset_no_more_writes", cap_b.size(), 5);
        chk("midreset_frame_cnt_after", {16'd0, frame_cnt}, exp_frames);
        chk("midreset_busy_after", {31'd0, busy}, 32'd0);

        // frame_cnt wrap
        force dut.frame_cnt_q = 16'hFFFF;
        step();
        release dut.frame_cnt_q;
        chk("wrap_preload", {16'd0, frame_cnt}, 32'h0000_FFFF);
        clear_cap();
        push_word(8'h77, 32'h01234567, acc);
        wait_idle(100);
        chk("wrap_frame_len", cap_b.size(), 9);
        chk("frame_cnt_wrap", {16'd0, frame_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
